pwm_capture: RTL

- Receive-side counterpart to the team's PWM LED driver.
- Samples an asynchronous PWM input and measures, for each PWM period, the period length and the high time in sys_clk cycles.
- Flags a stuck input (0 % or 100 % duty, or signal lost) after a timeout.
- Used for loop-back self-test of PWM generators and for reading external PWM sensors.

---
 rtl/pwm_pkg.sv | 14 +
 rtl/pwm_capture_if.sv | 22 ++
 rtl/pwm_edge_sync.sv | 31 +++
 rtl/pwm_capture.sv | 126 ++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared PWM definitions: capture FSM states and default counter/timeout sizing.
// The PWM generator uses the same defaults, so changing them here keeps both sides consistent.
package pwm_pkg;

  typedef enum logic [1:0] {
    WAIT_RISE = 2'd0,
    MEAS_HIGH = 2'd1,
    MEAS_LOW  = 2'd2
  } pwm_state_e;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 60000;

endpackage

// File: rtl/pwm_capture_if.sv
// PWM capture bundle: the sampled PWM line plus the measurement results.
// master is the capture block side; slave is the stimulus/consumer side.
interface pwm_capture_if #(
  parameter int CNT_W = pwm_pkg::CNT_W
);
  logic             pwm_in;
  logic             meas_valid;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             stuck;
  logic             stuck_level;

  modport master (
    input  pwm_in,
    output meas_valid, period, high_time, stuck, stuck_level
  );

  modport slave (
    output pwm_in,
    input  meas_valid, period, high_time, stuck, stuck_level
  );
endinterface

// File: rtl/pwm_edge_sync.sv
// Brings the asynchronous PWM line into the clock domain and derives one-cycle
// rise/fall pulses. There is no glitch filter, so pulses shorter than a clock may vanish.
module pwm_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic pwm_in,
  output logic pwm_s,
  output logic rise,
  output logic fall
);

  logic meta_r;
  logic pwm_d;

  // Two-flop synchroniser followed by one delay flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      pwm_s  <= 1'b0;
      pwm_d  <= 1'b0;
    end else begin
      meta_r <= pwm_in;
      pwm_s  <= meta_r;
      pwm_d  <= pwm_s;
    end
  end

  assign rise = pwm_s & ~pwm_d;
  assign fall = ~pwm_s & pwm_d;

endmodule

// File: rtl/pwm_capture.sv
// Measures the period and high time of an asynchronous PWM input in sys_clk cycles,
// and flags a stuck line when no edge arrives for TIMEOUT cycles.
module pwm_capture #(
  parameter int CNT_W   = pwm_pkg::CNT_W,
  parameter int TIMEOUT = pwm_pkg::TIMEOUT
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  pwm_capture_if.master bus
);

  import pwm_pkg::*;

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  logic pwm_s;
  logic rise;
  logic fall;

  pwm_edge_sync u_edge_sync (
    .clk    (sys_clk),
    .rst_n  (sys_rst_n),
    .pwm_in (bus.pwm_in),
    .pwm_s  (pwm_s),
    .rise   (rise),
    .fall   (fall)
  );

  pwm_state_e       state_r;
  logic [CNT_W-1:0] pcnt_r;
  logic [CNT_W-1:0] hcnt_r;
  logic [CNT_W-1:0] idle_r;
  logic [CNT_W-1:0] period_r;
  logic [CNT_W-1:0] high_r;
  logic             valid_r;
  logic             stuck_r;
  logic             level_r;
  logic             edge_s;
  logic             timeout_s;

  // An edge in the very cycle the idle count would expire suppresses the timeout
  assign edge_s    = rise | fall;
  assign timeout_s = !edge_s && (idle_r == IDLE_LAST);

  // Idle timer and stuck flag with the line level captured at expiry
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      idle_r  <= CNT_ZERO;
      stuck_r <= 1'b0;
      level_r <= 1'b0;
    end else if (edge_s) begin
      idle_r  <= CNT_ZERO;
      stuck_r <= 1'b0;
    end else begin
      idle_r <= sat_inc(idle_r);
      if (timeout_s) begin
        stuck_r <= 1'b1;
        level_r <= pwm_s;
      end
    end
  end

  // Measurement FSM; a timeout discards the partial measurement
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r  <= WAIT_RISE;
      pcnt_r   <= CNT_ZERO;
      hcnt_r   <= CNT_ZERO;
      period_r <= CNT_ZERO;
      high_r   <= CNT_ZERO;
      valid_r  <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      if (timeout_s) begin
        state_r <= WAIT_RISE;
      end else begin
        case (state_r)
          WAIT_RISE: begin
            if (rise) begin
              pcnt_r  <= CNT_ONE;
              hcnt_r  <= CNT_ONE;
              state_r <= MEAS_HIGH;
            end
          end
          MEAS_HIGH: begin
            pcnt_r <= sat_inc(pcnt_r);
            if (fall) begin
              state_r <= MEAS_LOW;
            end else begin
              hcnt_r <= sat_inc(hcnt_r);
            end
          end
          MEAS_LOW: begin
            if (rise) begin
              period_r <= pcnt_r;
              high_r   <= hcnt_r;
              valid_r  <= 1'b1;
              pcnt_r   <= CNT_ONE;
              hcnt_r   <= CNT_ONE;
              state_r  <= MEAS_HIGH;
            end else begin
              pcnt_r <= sat_inc(pcnt_r);
            end
          end
          default: begin
            state_r <= WAIT_RISE;
          end
        endcase
      end
    end
  end

  assign bus.meas_valid  = valid_r;
  assign bus.period      = period_r;
  assign bus.high_time   = high_r;
  assign bus.stuck       = stuck_r;
  assign bus.stuck_level = level_r;

endmodule
